// File: rtl/tl_pkg.sv
// Shared TileLink A/D channel definitions: opcodes, arbiter state encoding and
// burst-length helpers used by the arbiters and their beat counters.
package tl_pkg;

   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] ARITH       = 3'd2;
   localparam logic [2:0] LOGIC       = 3'd3;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] HINT        = 3'd5;
   localparam logic [2:0] ACQUIRE     = 3'd6;

   localparam int TL_MAX_SIZE = 6;
   localparam int TL_DATA_W   = 64;
   localparam int BEAT_W      = TL_MAX_SIZE - $clog2(TL_DATA_W / 8);

   typedef enum logic [1:0] {
      IDLE,
      LOCK,
      BURST
   } arb_state_e;

   // Only PutFull/PutPartial/Arith/Logic carry data on A; everything else is one beat.
   function automatic logic [BEAT_W:0] beats_of(input logic [2:0] opcode,
                                                input logic [2:0] size);
      logic [BEAT_W:0] beats;
      beats = (BEAT_W + 1)'(1);
      if (opcode <= LOGIC && size > 3'd3)
         beats = (BEAT_W + 1)'(1) << (size - 3'd3);
      return beats;
   endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Remaining-beat counter for a granted A burst: loads beats-1 on the first
// beat, counts down on every later beat and flags the final one.
module tl_beat_counter
   import tl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [BEAT_W-1:0] load_val,
   input  logic              dec,
   output logic              last
);

   logic [BEAT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - 1'b1;
   end

   assign last = (count == BEAT_W'(1));

endmodule

// File: rtl/tl_a_arb2.sv
// Two-requester round-robin A-channel arbiter with D-channel response routing.
// Optional performance counters are built when TL_A_ARB2_PERF_EN is defined.
module tl_a_arb2
   import tl_pkg::*;
#(
   parameter int SRC_W    = 3,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 64,
   parameter int MAX_SIZE = 6
) (
   input  logic                clock,
   input  logic                reset,

   input  logic                a0_valid,
   output logic                a0_ready,
   input  logic [2:0]          a0_opcode,
   input  logic [2:0]          a0_param,
   input  logic [2:0]          a0_size,
   input  logic [SRC_W-1:0]    a0_source,
   input  logic [ADDR_W-1:0]   a0_address,
   input  logic [DATA_W-1:0]   a0_data,
   input  logic [DATA_W/8-1:0] a0_mask,
   input  logic                a0_corrupt,

   input  logic                a1_valid,
   output logic                a1_ready,
   input  logic [2:0]          a1_opcode,
   input  logic [2:0]          a1_param,
   input  logic [2:0]          a1_size,
   input  logic [SRC_W-1:0]    a1_source,
   input  logic [ADDR_W-1:0]   a1_address,
   input  logic [DATA_W-1:0]   a1_data,
   input  logic [DATA_W/8-1:0] a1_mask,
   input  logic                a1_corrupt,

   output logic                o_a_valid,
   input  logic                o_a_ready,
   output logic [2:0]          o_a_opcode,
   output logic [2:0]          o_a_param,
   output logic [2:0]          o_a_size,
   output logic [SRC_W:0]      o_a_source,
   output logic [ADDR_W-1:0]   o_a_address,
   output logic [DATA_W-1:0]   o_a_data,
   output logic [DATA_W/8-1:0] o_a_mask,
   output logic                o_a_corrupt,

   input  logic                i_d_valid,
   output logic                i_d_ready,
   input  logic [2:0]          i_d_opcode,
   input  logic [2:0]          i_d_param,
   input  logic [2:0]          i_d_size,
   input  logic [SRC_W:0]      i_d_source,
   input  logic [DATA_W-1:0]   i_d_data,
   input  logic                i_d_denied,
   input  logic                i_d_corrupt,

   output logic                d0_valid,
   input  logic                d0_ready,
   output logic [2:0]          d0_opcode,
   output logic [2:0]          d0_param,
   output logic [2:0]          d0_size,
   output logic [SRC_W-1:0]    d0_source,
   output logic [DATA_W-1:0]   d0_data,
   output logic                d0_denied,
   output logic                d0_corrupt,

   output logic                d1_valid,
   input  logic                d1_ready,
   output logic [2:0]          d1_opcode,
   output logic [2:0]          d1_param,
   output logic [2:0]          d1_size,
   output logic [SRC_W-1:0]    d1_source,
   output logic [DATA_W-1:0]   d1_data,
   output logic                d1_denied,
   output logic                d1_corrupt
`ifdef TL_A_ARB2_PERF_EN
   ,
   output logic [31:0]         perf_msg0,
   output logic [31:0]         perf_msg1,
   output logic [31:0]         perf_stall
`endif
);

   arb_state_e      state;
   logic            grant;
   logic            prio;
   logic            sel_idle;
   logic            sel;
   logic            sel_valid;
   logic            a_fire;
   logic [BEAT_W:0] cur_beats;
   logic            multi;
   logic            cnt_load;
   logic            cnt_dec;
   logic            cnt_last;
   logic            d_route;

   // Once a request has been presented (LOCK) or a burst started, the mux is pinned to grant.
   assign sel_idle  = (a0_valid && a1_valid) ? prio : a1_valid;
   assign sel       = (state == IDLE) ? sel_idle : grant;
   assign sel_valid = sel ? a1_valid : a0_valid;

   assign o_a_valid   = !reset && sel_valid;
   assign o_a_opcode  = sel ? a1_opcode  : a0_opcode;
   assign o_a_param   = sel ? a1_param   : a0_param;
   assign o_a_size    = sel ? a1_size    : a0_size;
   assign o_a_source  = {sel, (sel ? a1_source : a0_source)};
   assign o_a_address = sel ? a1_address : a0_address;
   assign o_a_data    = sel ? a1_data    : a0_data;
   assign o_a_mask    = sel ? a1_mask    : a0_mask;
   assign o_a_corrupt = sel ? a1_corrupt : a0_corrupt;

   assign a0_ready = !reset && !sel && o_a_ready;
   assign a1_ready = !reset &&  sel && o_a_ready;

   assign a_fire    = o_a_valid && o_a_ready;
   assign cur_beats = beats_of(o_a_opcode, o_a_size);
   assign multi     = cur_beats > (BEAT_W + 1)'(1);
   assign cnt_load  = a_fire && (state != BURST) && multi;
   assign cnt_dec   = a_fire && (state == BURST);

   tl_beat_counter u_beat_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (BEAT_W'(cur_beats - 1'b1)),
      .dec      (cnt_dec),
      .last     (cnt_last)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         grant <= 1'b0;
         prio  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (a_fire) begin
                  if (multi) begin
                     grant <= sel;
                     state <= BURST;
                  end else begin
                     prio <= ~sel;
                  end
               end else if (o_a_valid) begin
                  grant <= sel;
                  state <= LOCK;
               end
            end
            LOCK: begin
               if (a_fire) begin
                  if (multi) begin
                     state <= BURST;
                  end else begin
                     state <= IDLE;
                     prio  <= ~grant;
                  end
               end
            end
            BURST: begin
               if (a_fire && cnt_last) begin
                  state <= IDLE;
                  prio  <= ~grant;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && o_a_valid)
         assert (o_a_size <= 3'(MAX_SIZE));
   end

   // D responses are steered purely by the requester tag in the source MSB.
   assign d_route   = i_d_source[SRC_W];
   assign d0_valid  = !reset && i_d_valid && !d_route;
   assign d1_valid  = !reset && i_d_valid &&  d_route;
   assign i_d_ready = !reset && (d_route ? d1_ready : d0_ready);

   assign d0_opcode  = i_d_opcode;
   assign d0_param   = i_d_param;
   assign d0_size    = i_d_size;
   assign d0_source  = i_d_source[SRC_W-1:0];
   assign d0_data    = i_d_data;
   assign d0_denied  = i_d_denied;
   assign d0_corrupt = i_d_corrupt;

   assign d1_opcode  = i_d_opcode;
   assign d1_param   = i_d_param;
   assign d1_size    = i_d_size;
   assign d1_source  = i_d_source[SRC_W-1:0];
   assign d1_data    = i_d_data;
   assign d1_denied  = i_d_denied;
   assign d1_corrupt = i_d_corrupt;

`ifdef TL_A_ARB2_PERF_EN
   logic msg_done;

   assign msg_done = a_fire && ((state == BURST) ? cnt_last : !multi);

   always_ff @(posedge clock) begin
      if (reset) begin
         perf_msg0  <= '0;
         perf_msg1  <= '0;
         perf_stall <= '0;
      end else begin
         if (msg_done && !sel && perf_msg0 != '1)
            perf_msg0 <= perf_msg0 + 32'd1;
         if (msg_done && sel && perf_msg1 != '1)
            perf_msg1 <= perf_msg1 + 32'd1;
         if (o_a_valid && !o_a_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tl_a_arb2.sv
// Directed self-checking bench for tl_a_arb2: reset, round-robin, burst hold,
// lock under back-pressure, D routing, mid-burst reset and optional perf counters.
module tb_tl_a_arb2;
   import tl_pkg::*;

   localparam int SRC_W  = 3;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;

   logic clock, reset;
   logic a0_valid, a0_ready, a0_corrupt, a1_valid, a1_ready, a1_corrupt;
   logic [2:0] a0_opcode, a0_param, a0_size, a1_opcode, a1_param, a1_size;
   logic [SRC_W-1:0] a0_source, a1_source;
   logic [ADDR_W-1:0] a0_address, a1_address;
   logic [DATA_W-1:0] a0_data, a1_data;
   logic [DATA_W/8-1:0] a0_mask, a1_mask;
   logic o_a_valid, o_a_ready, o_a_corrupt;
   logic [2:0] o_a_opcode, o_a_param, o_a_size;
   logic [SRC_W:0] o_a_source;
   logic [ADDR_W-1:0] o_a_address;
   logic [DATA_W-1:0] o_a_data;
   logic [DATA_W/8-1:0] o_a_mask;
   logic i_d_valid, i_d_ready, i_d_denied, i_d_corrupt;
   logic [2:0] i_d_opcode, i_d_param, i_d_size;
   logic [SRC_W:0] i_d_source;
   logic [DATA_W-1:0] i_d_data;
   logic d0_valid, d0_ready, d0_denied, d0_corrupt;
   logic d1_valid, d1_ready, d1_denied, d1_corrupt;
   logic [2:0] d0_opcode, d0_param, d0_size, d1_opcode, d1_param, d1_size;
   logic [SRC_W-1:0] d0_source, d1_source;
   logic [DATA_W-1:0] d0_data, d1_data;
`ifdef TL_A_ARB2_PERF_EN
   logic [31:0] perf_msg0, perf_msg1, perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   tl_a_arb2 dut (
      .clock(clock), .reset(reset),
      .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
      .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_data(a0_data),
      .a0_mask(a0_mask), .a0_corrupt(a0_corrupt),
      .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
      .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_data(a1_data),
      .a1_mask(a1_mask), .a1_corrupt(a1_corrupt),
      .o_a_valid(o_a_valid), .o_a_ready(o_a_ready), .o_a_opcode(o_a_opcode), .o_a_param(o_a_param),
      .o_a_size(o_a_size), .o_a_source(o_a_source), .o_a_address(o_a_address), .o_a_data(o_a_data),
      .o_a_mask(o_a_mask), .o_a_corrupt(o_a_corrupt),
      .i_d_valid(i_d_valid), .i_d_ready(i_d_ready), .i_d_opcode(i_d_opcode), .i_d_param(i_d_param),
      .i_d_size(i_d_size), .i_d_source(i_d_source), .i_d_data(i_d_data), .i_d_denied(i_d_denied),
      .i_d_corrupt(i_d_corrupt),
      .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_param(d0_param),
      .d0_size(d0_size), .d0_source(d0_source), .d0_data(d0_data), .d0_denied(d0_denied),
      .d0_corrupt(d0_corrupt),
      .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_param(d1_param),
      .d1_size(d1_size), .d1_source(d1_source), .d1_data(d1_data), .d1_denied(d1_denied),
      .d1_corrupt(d1_corrupt)
`ifdef TL_A_ARB2_PERF_EN
      , .perf_msg0(perf_msg0), .perf_msg1(perf_msg1), .perf_stall(perf_stall)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic applyStimulus(input int n, input logic valid, input logic [2:0] opcode,
                                input logic [2:0] size, input logic [SRC_W-1:0] source,
                                input logic [ADDR_W-1:0] address, input logic [DATA_W-1:0] data);
      if (n == 0) begin
         a0_valid = valid; a0_opcode = opcode; a0_size = size;
         a0_source = source; a0_address = address; a0_data = data;
      end else begin
         a1_valid = valid; a1_opcode = opcode; a1_size = size;
         a1_source = source; a1_address = address; a1_data = data;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b1;
      a0_param = 3'd0; a1_param = 3'd0; a0_mask = 8'hFF; a1_mask = 8'h0F;
      a0_corrupt = 1'b0; a1_corrupt = 1'b0;
      applyStimulus(0, 1'b1, GET, 3'd3, 3'd5, 32'h0000_1000, 64'hA0);
      applyStimulus(1, 1'b1, GET, 3'd3, 3'd2, 32'h0000_2000, 64'hB0);
      o_a_ready = 1'b1;
      i_d_valid = 1'b1; i_d_opcode = 3'd1; i_d_param = 3'd0; i_d_size = 3'd3;
      i_d_source = 4'b1000; i_d_data = 64'hD0; i_d_denied = 1'b0; i_d_corrupt = 1'b0;
      d0_ready = 1'b1; d1_ready = 1'b1;

      // Reset holds every handshake low.
      @(negedge clock);
      @(negedge clock); #1;
      checkOutput("rst_o_a_valid", o_a_valid, 1'b0);
      checkOutput("rst_a0_ready", a0_ready, 1'b0);
      checkOutput("rst_a1_ready", a1_ready, 1'b0);
      checkOutput("rst_i_d_ready", i_d_ready, 1'b0);
      checkOutput("rst_d0_valid", d0_valid, 1'b0);
      checkOutput("rst_d1_valid", d1_valid, 1'b0);

      // Both requesters valid: req0 first, then req1.
      @(negedge clock);
      reset = 1'b0; i_d_valid = 1'b0;
      #1;
      checkOutput("rr0_valid", o_a_valid, 1'b1);
      checkOutput("rr0_source", o_a_source, 4'b0101);
      checkOutput("rr0_address", o_a_address, 32'h0000_1000);
      checkOutput("rr0_a0_ready", a0_ready, 1'b1);
      checkOutput("rr0_a1_ready", a1_ready, 1'b0);
      @(negedge clock); #1;
      checkOutput("rr1_source", o_a_source, 4'b1010);
      checkOutput("rr1_address", o_a_address, 32'h0000_2000);
      checkOutput("rr1_a1_ready", a1_ready, 1'b1);
      checkOutput("rr1_a0_ready", a0_ready, 1'b0);

      // 8-beat PutFull from req0 holds the grant against a waiting req1.
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         applyStimulus(0, 1'b1, PUT_FULL, 3'd6, 3'd1, 32'h0000_3000, 64'h100 + 64'(i));
         #1;
         checkOutput("burst_source", o_a_source, 4'b0001);
         checkOutput("burst_data", o_a_data, 64'h100 + 64'(i));
         checkOutput("burst_a1_ready", a1_ready, 1'b0);
      end
      @(negedge clock); #1;
      checkOutput("post_burst_source", o_a_source, 4'b1010);
      checkOutput("post_burst_a1_ready", a1_ready, 1'b1);
      checkOutput("post_burst_a0_ready", a0_ready, 1'b0);

      // req1 stalled for 4 cycles keeps the lock even after req0 arrives.
      @(negedge clock);
      applyStimulus(0, 1'b0, GET, 3'd3, 3'd4, 32'h0000_4000, 64'h0);
      applyStimulus(1, 1'b1, GET, 3'd3, 3'd6, 32'h0000_5000, 64'h0);
      o_a_ready = 1'b0;
      #1;
      checkOutput("lock_c1_source", o_a_source, 4'b1110);
      for (int c = 2; c <= 4; c++) begin
         @(negedge clock);
         a0_valid = 1'b1;
         #1;
         checkOutput("lock_source", o_a_source, 4'b1110);
         checkOutput("lock_address", o_a_address, 32'h0000_5000);
         checkOutput("lock_a0_ready", a0_ready, 1'b0);
      end
      @(negedge clock);
      o_a_ready = 1'b1;
      #1;
      checkOutput("lock_fire_a1_ready", a1_ready, 1'b1);
      checkOutput("lock_fire_source", o_a_source, 4'b1110);
      @(negedge clock);
      a1_valid = 1'b0;
      #1;
      checkOutput("lock_after_source", o_a_source, 4'b0100);
      checkOutput("lock_after_a0_ready", a0_ready, 1'b1);

      // D responses routed by the source MSB.
      @(negedge clock);
      a0_valid = 1'b0;
      i_d_valid = 1'b1; i_d_source = 4'b1011; i_d_data = 64'hDEAD_BEEF; d1_ready = 1'b0;
      #1;
      checkOutput("d1_valid", d1_valid, 1'b1);
      checkOutput("d1_source", d1_source, 3'b011);
      checkOutput("d0_valid_off", d0_valid, 1'b0);
      checkOutput("d_ready_low1", i_d_ready, 1'b0);
      @(negedge clock); #1;
      checkOutput("d_ready_low2", i_d_ready, 1'b0);
      @(negedge clock);
      d1_ready = 1'b1;
      #1;
      checkOutput("d_ready_high", i_d_ready, 1'b1);
      checkOutput("d0_data_bcast", d0_data, 64'hDEAD_BEEF);
      @(negedge clock);
      i_d_source = 4'b0110; d0_ready = 1'b0;
      #1;
      checkOutput("d0_valid", d0_valid, 1'b1);
      checkOutput("d1_valid_off", d1_valid, 1'b0);
      checkOutput("d0_source", d0_source, 3'b110);
      checkOutput("d0_ready_route", i_d_ready, 1'b0);

      // Reset after beat 3 of a req1 burst restarts arbitration with prio 0.
      @(negedge clock);
      i_d_valid = 1'b0; d0_ready = 1'b1;
      applyStimulus(0, 1'b1, GET, 3'd3, 3'd3, 32'h0000_6000, 64'h0);
      applyStimulus(1, 1'b1, PUT_FULL, 3'd6, 3'd7, 32'h0000_7000, 64'h0);
      #1;
      checkOutput("rb_beat1_source", o_a_source, 4'b1111);
      for (int b = 2; b <= 3; b++) begin
         @(negedge clock); #1;
         checkOutput("rb_beat_source", o_a_source, 4'b1111);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("rb_rst_o_a_valid", o_a_valid, 1'b0);
      checkOutput("rb_rst_a1_ready", a1_ready, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checkOutput("rb_after_source", o_a_source, 4'b0011);
      checkOutput("rb_after_opcode", o_a_opcode, GET);
      checkOutput("rb_after_a0_ready", a0_ready, 1'b1);
      checkOutput("rb_after_a1_ready", a1_ready, 1'b0);

`ifdef TL_A_ARB2_PERF_EN
      @(negedge clock);
      reset = 1'b1; a0_valid = 1'b0; a1_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      for (int g = 0; g < 3; g++) begin
         @(negedge clock);
         applyStimulus(0, 1'b1, GET, 3'd3, 3'd1, 32'h0000_8000, 64'h0);
      end
      @(negedge clock);
      a0_valid = 1'b0;
      applyStimulus(1, 1'b1, PUT_FULL, 3'd5, 3'd2, 32'h0000_9000, 64'h0);
      @(negedge clock);
      o_a_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      o_a_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      a1_valid = 1'b0;
      @(negedge clock); #1;
      checkOutput("perf_msg0", perf_msg0, 32'd3);
      checkOutput("perf_msg1", perf_msg1, 32'd1);
      checkOutput("perf_stall", perf_stall, 32'd2);
`endif

      @(negedge clock);
      a0_valid = 1'b0; a1_valid = 1'b0;
      @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
